// File: rtl/reset_sequencer_if.sv
// Sequencer-side signal bundle: soft-reset request in, reset lines and status out.
// Latency: n/a (wires only).
// Backpressure: none; all outputs are level/pulse signals with no handshake.
interface reset_sequencer_if;
    logic        Soft_Reset;
    logic        Clk_Reset;
    logic        PC_Reset;
    logic        Clk_En;
    logic        Ready;
    logic [1:0]  State;
    logic [31:0] Run_Cycles;

    // The sequencer drives the reset lines and status, and samples the soft request
    modport master (
        input  Soft_Reset,
        output Clk_Reset,
        output PC_Reset,
        output Clk_En,
        output Ready,
        output State,
        output Run_Cycles
    );

    // The consumer (CPU top / bench) requests soft resets and observes everything else
    modport slave (
        output Soft_Reset,
        input  Clk_Reset,
        input  PC_Reset,
        input  Clk_En,
        input  Ready,
        input  State,
        input  Run_Cycles
    );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on/soft reset sequencer: releases Clk_Reset, then PC_Reset, and emits a divided Clk_En.
// Latency: all outputs are registered; they reflect the state entered on the previous Clk edge.
// Backpressure: none; Soft_Reset is only honoured in S_RUN, Reset overrides everything.
// Optional build macro RESET_SEQ_CYCLE_COUNTER_EN enables the Run_Cycles counter (else tied to 0).
module reset_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int DIV         = 2,
    parameter int PC_DELAY    = 1,
    parameter int SOFT_CYCLES = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    reset_sequencer_if.master  bus
);

    // Phase counter must hold values up to the largest terminal count
    localparam int CNT_MAX_A = (HOLD_CYCLES > PC_DELAY) ? HOLD_CYCLES : PC_DELAY;
    localparam int CNT_MAX   = (CNT_MAX_A > SOFT_CYCLES) ? CNT_MAX_A : SOFT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    // DIV=1 still needs a one-bit divider register to keep the logic uniform
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PC_LAST   = CNT_W'(PC_DELAY - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_HOLD  = 2'b00,
        S_CLKUP = 2'b01,
        S_RUN   = 2'b10,
        S_SOFT  = 2'b11
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] nxt_div;

    logic             clk_reset_q;
    logic             pc_reset_q;
    logic             clk_en_q;
    logic             ready_q;
    logic [1:0]       state_q;

    // Next-state, phase-counter and divider logic; Reset is applied last so it wins
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_div   = '0;

        // Divider is parked at 0 while the clock divider itself is held in reset
        if (state != S_HOLD) begin
            nxt_div = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end

        case (state)
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    nxt_state = S_CLKUP;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt   = cnt + CNT_W'(1);
                end
            end
            S_CLKUP: begin
                if (clk_en_q) begin
                    if (cnt == PC_LAST) begin
                        nxt_state = S_RUN;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt   = cnt + CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (bus.Soft_Reset) begin
                    nxt_state = S_SOFT;
                    nxt_cnt   = '0;
                end
            end
            S_SOFT: begin
                if (clk_en_q) begin
                    if (cnt == SOFT_LAST) begin
                        nxt_state = S_RUN;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt   = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                nxt_state = S_HOLD;
                nxt_cnt   = '0;
            end
        endcase

        if (Reset) begin
            nxt_state = S_HOLD;
            nxt_cnt   = '0;
            nxt_div   = '0;
        end
    end

    // Sequencer FSM: state, counters and every output registered from the next-state values
    always_ff @(posedge Clk) begin
        state       <= nxt_state;
        cnt         <= nxt_cnt;
        div_cnt     <= nxt_div;
        clk_reset_q <= (nxt_state == S_HOLD);
        pc_reset_q  <= (nxt_state != S_RUN);
        ready_q     <= (nxt_state == S_RUN);
        clk_en_q    <= (nxt_state != S_HOLD) && (nxt_div == DIV_LAST);
        state_q     <= nxt_state;
    end

    assign bus.Clk_Reset = clk_reset_q;
    assign bus.PC_Reset  = pc_reset_q;
    assign bus.Clk_En    = clk_en_q;
    assign bus.Ready     = ready_q;
    assign bus.State     = state_q;

`ifdef RESET_SEQ_CYCLE_COUNTER_EN
    logic [31:0] run_cycles_q;
    logic        run_clr;
    logic        run_inc;

    // Entering S_SOFT restarts the run-time count; Reset clears it too
    assign run_clr = Reset || ((state == S_RUN) && (nxt_state == S_SOFT));
    assign run_inc = (state == S_RUN) && clk_en_q;

    // Count Clk_En pulses spent in S_RUN; natural 32-bit wrap
    always_ff @(posedge Clk) begin
        if (run_clr) begin
            run_cycles_q <= '0;
        end else if (run_inc) begin
            run_cycles_q <= run_cycles_q + 32'd1;
        end
    end

    assign bus.Run_Cycles = run_cycles_q;
`else
    assign bus.Run_Cycles = 32'h0;
`endif

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Synthesizable power-on/soft reset sequencer for the single-cycle MIPS top.
- Generates the two reset lines the top consumes (Clk_Reset for the clock divider, PC_Reset for the program counter), releasing them in the order and for the hold times the datapath needs.
- Also produces a divided clock-enable pulse and a Ready flag.
- Replaces bench-driven reset timing, so the same sequence runs on the board.

Parameters:
- HOLD_CYCLES, 4: Clk edges Clk_Reset stays high after Reset deasserts (min 1).
- DIV, 2: Clk_En period in Clk cycles (min 1; 1 means Clk_En is constant high outside S_HOLD).
- PC_DELAY, 1: Clk_En pulses between Clk_Reset release and PC_Reset release (min 1).
- SOFT_CYCLES, 2: Clk_En pulses PC_Reset is held for a soft reset (min 1).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high; overrides everything.
- Soft_Reset  input  1  request to re-reset the PC only; sampled in S_RUN only.
- Clk_Reset  output  1  divider reset; high iff state==S_HOLD.
- PC_Reset  output  1  PC reset; high iff state!=S_RUN.
- Clk_En  output  1  one-cycle enable pulse every DIV cycles.
- Ready  output  1  high iff state==S_RUN.
- State  output  2  current state encoding (debug).
- Run_Cycles  output  32  see Optional Feature.

Behaviour:
- State encoding: S_HOLD=00, S_CLKUP=01, S_RUN=10, S_SOFT=11. Registers: state, cnt (phase counter), div_cnt.
- Reset=1 at an edge:
  - state=S_HOLD, cnt=0, div_cnt=0.
  - Outputs after that edge: Clk_Reset=1, PC_Reset=1, Clk_En=0, Ready=0, State=00, Run_Cycles=0.
- Divider:
  - div_cnt is held at 0 in S_HOLD.
  - Otherwise div_cnt increments mod DIV every edge.
  - Clk_En = (state!=S_HOLD) && (div_cnt==DIV-1), decoded from registered state.
- S_HOLD:
  - cnt increments each edge.
  - On the edge where cnt==HOLD_CYCLES-1, go to S_CLKUP with cnt=0.
  - Result: Clk_Reset falls after the HOLD_CYCLES-th edge with Reset low.
- S_CLKUP:
  - cnt increments on each edge where Clk_En=1.
  - On the edge where Clk_En=1 and cnt==PC_DELAY-1, go to S_RUN with cnt=0.
- S_RUN:
  - If Soft_Reset=1 at an edge, go to S_SOFT with cnt=0.
  - div_cnt keeps free-running, and Clk_Reset stays 0.
- S_SOFT:
  - PC_Reset=1, Ready=0.
  - cnt increments on each Clk_En edge.
  - On the edge where Clk_En=1 and cnt==SOFT_CYCLES-1, return to S_RUN.
  - Soft_Reset is ignored in S_SOFT, S_CLKUP and S_HOLD. A held Soft_Reset re-enters S_SOFT on the first S_RUN edge.
- Simultaneous events: Reset beats Soft_Reset and every counter terminal condition. A Reset asserted in any state returns to S_HOLD on that edge.
- Counter widths: cnt is wide enough for max(HOLD_CYCLES, PC_DELAY, SOFT_CYCLES); div_cnt is wide enough for DIV. No counter overflows for legal parameters.

Optional Feature:
- Macro: RESET_SEQ_CYCLE_COUNTER_EN.
- Defined:
  - Run_Cycles is a 32-bit register that increments on each edge where state==S_RUN and Clk_En=1.
  - It clears to 0 on Reset and on the edge entering S_SOFT.
  - It wraps 0xFFFFFFFF to 0.
- Undefined: Run_Cycles is tied to 32'h0 and no counter logic is synthesized. The port list is unchanged.

Test Plan:
1. Power-on, defaults: Reset=1 for 3 edges, then low (first low edge e1):
   - Clk_Reset=1 through e4 and 0 after e4.
   - First Clk_En high in the cycle after e5.
   - PC_Reset=0 and Ready=1 after e6; State sequence 00,00,00,00,01,01,10.
2. DIV=1, defaults otherwise:
   - Clk_En=1 in every cycle from the first S_CLKUP cycle.
   - PC_Reset falls one edge after Clk_Reset falls.
3. Soft reset in S_RUN with defaults, one-cycle Soft_Reset pulse:
   - PC_Reset=1 and Ready=0 after the sampling edge; Clk_Reset stays 0.
   - Return to S_RUN on the edge sampling the 2nd Clk_En pulse (3–4 Clk cycles depending on div phase).
   - Soft_Reset pulses during S_SOFT have no effect.
4. Reset mid-S_SOFT and mid-S_RUN:
   - Next edge gives State=00, Clk_Reset=1, PC_Reset=1, Clk_En=0, Run_Cycles=0.
   - The full sequence from scenario 1 repeats exactly.
5. Simultaneous Reset=1 and Soft_Reset=1 in S_RUN: state goes to S_HOLD, not S_SOFT.
6. RESET_SEQ_CYCLE_COUNTER_EN defined, DIV=2:
   - After 10 Clk_En pulses in S_RUN, Run_Cycles=10.
   - A soft reset clears it to 0.
   - Force 0xFFFFFFFF then one pulse gives 0.
   - Macro undefined: Run_Cycles=0 throughout.
